// File: rtl/button_input_pkg.sv
// Shared definitions for the button front end.
//   in_state_t   : colour-path FSM states
//   COLOR_0..3   : colour codes shared with the controller and display
//   is_onehot    : true when exactly one colour bit is set
//   enc_onehot   : one-hot colour vector to 2-bit colour code
package button_input_pkg;

  typedef enum logic [1:0] {
    IN_IDLE_S       = 2'd0,
    IN_PRESS_DB_S   = 2'd1,
    IN_HELD_S       = 2'd2,
    IN_RELEASE_DB_S = 2'd3
  } in_state_t;

  localparam logic [1:0] COLOR_0 = 2'd0;
  localparam logic [1:0] COLOR_1 = 2'd1;
  localparam logic [1:0] COLOR_2 = 2'd2;
  localparam logic [1:0] COLOR_3 = 2'd3;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Only called with a one-hot argument; bit 0 wins any ambiguity.
  function automatic logic [1:0] enc_onehot(input logic [3:0] v);
    logic [1:0] code;
    code = COLOR_0;
    if (v[3]) code = COLOR_3;
    if (v[2]) code = COLOR_2;
    if (v[1]) code = COLOR_1;
    if (v[0]) code = COLOR_0;
    return code;
  endfunction

endpackage

// File: rtl/button_input_btn_debounce.sv
// Single-bit level debouncer: 2-flop synchroniser followed by a stable-count
// filter. The output follows the synchronised input only after it has differed
// from the current output for DB_CYCLES consecutive clocks.
//   CLK     : system clock
//   RST     : synchronous active-high reset
//   BTN_RAW : raw asynchronous button level
//   BTN_DB  : debounced level
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_RAW,
  output logic BTN_DB
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= BTN_RAW;
      sync <= meta;
      if (sync != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any return to the current level restarts the count.
        cnt <= '0;
      end
    end
  end

  assign BTN_DB = level;

endmodule

// File: rtl/button_input.sv
// Button front end for the game controller.
// Synchronises and debounces four colour buttons and a start button, rejects
// multi-button presses, and presents one encoded colour whose valid flag stays
// high for the whole debounced press.
//   CLK        : system clock
//   RST        : synchronous active-high reset
//   BTN[3:0]   : raw colour buttons, bit n = colour n
//   BTN_START  : raw start button
//   BTN_CODE   : encoded colour of the accepted press (held until next press)
//   BTN_VALID  : high while a debounced single press is held
//   START_GAME : debounced start-button level
module button_input
  import button_input_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       BTN_START,
  output logic [1:0] BTN_CODE,
  output logic       BTN_VALID,
  output logic       START_GAME
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       btn_meta;
  logic [3:0]       btn_sync;

  in_state_t        state,  state_n;
  logic [3:0]       cap,    cap_n;
  logic [CNT_W-1:0] cnt,    cnt_n;
  logic [1:0]       code_q, code_n;
  logic             valid_q, valid_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= BTN;
      btn_sync <= btn_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IN_IDLE_S;
      cap     <= '0;
      cnt     <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      cap     <= cap_n;
      cnt     <= cnt_n;
      code_q  <= code_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    cap_n   = cap;
    cnt_n   = cnt;
    code_n  = code_q;
    valid_n = valid_q;
    unique case (state)
      IN_IDLE_S: begin
        if (is_onehot(btn_sync)) begin
          cap_n   = btn_sync;
          cnt_n   = '0;
          state_n = IN_PRESS_DB_S;
        end
      end
      IN_PRESS_DB_S: begin
        if (btn_sync != cap) begin
          state_n = IN_IDLE_S;
        end else if (cnt == CNT_LAST) begin
          state_n = IN_HELD_S;
          code_n  = enc_onehot(cap);
          valid_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IN_HELD_S: begin
        // Extra buttons while held are ignored; only a full release counts.
        if (btn_sync == 4'b0000) begin
          cnt_n   = '0;
          state_n = IN_RELEASE_DB_S;
        end
      end
      IN_RELEASE_DB_S: begin
        // Valid stays high here so a release bounce never glitches it.
        if (btn_sync != 4'b0000) begin
          state_n = IN_HELD_S;
        end else if (cnt == CNT_LAST) begin
          valid_n = 1'b0;
          state_n = IN_IDLE_S;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IN_IDLE_S;
        valid_n = 1'b0;
      end
    endcase
  end

  assign BTN_CODE  = code_q;
  assign BTN_VALID = valid_q;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_start_db (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_RAW (BTN_START),
    .BTN_DB  (START_GAME)
  );

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input. Stimulus pushes each expected output
// change (edge number plus output values) into a queue; monitors pop and
// compare whenever the DUT outputs change.
module tb_button_input;

  typedef struct packed {
    int unsigned cyc;
    logic        v;
    logic [1:0]  code;
    logic        st;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BTN = 4'b0000;
  logic       BTN_START = 1'b0;
  logic [1:0] BTN_CODE;
  logic       BTN_VALID;
  logic       START_GAME;

  logic [3:0] btn1 = 4'b0000;
  logic       start1 = 1'b0;
  logic [1:0] code1;
  logic       valid1;
  logic       start_game1;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         q0[$];
  ev_t         q1[$];
  logic [3:0]  prev0 = 4'b0000;
  logic [3:0]  prev1 = 4'b0000;
  logic        mon_en = 1'b0;

  button_input #(
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN        (BTN),
    .BTN_START  (BTN_START),
    .BTN_CODE   (BTN_CODE),
    .BTN_VALID  (BTN_VALID),
    .START_GAME (START_GAME)
  );

  button_input #(
    .DB_CYCLES (1),
    .CNT_W     (1)
  ) u_dut1 (
    .CLK        (CLK),
    .RST        (RST),
    .BTN        (btn1),
    .BTN_START  (start1),
    .BTN_CODE   (code1),
    .BTN_VALID  (valid1),
    .START_GAME (start_game1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    logic [3:0] cur;
    ev_t e;
    cur = {BTN_VALID, BTN_CODE, START_GAME};
    if (mon_en && cur !== prev0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL db4_event unexpected at cyc=%0d got v=%0b code=%0d st=%0b",
                 cyc, cur[3], cur[2:1], cur[0]);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || cur !== {e.v, e.code, e.st}) begin
          errors++;
          $display("FAIL db4_event got cyc=%0d v=%0b code=%0d st=%0b exp cyc=%0d v=%0b code=%0d st=%0b",
                   cyc, cur[3], cur[2:1], cur[0], e.cyc, e.v, e.code, e.st);
        end
      end
    end
    prev0 = cur;
  end

  always @(negedge CLK) begin
    logic [3:0] cur;
    ev_t e;
    cur = {valid1, code1, start_game1};
    if (mon_en && cur !== prev1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL db1_event unexpected at cyc=%0d got v=%0b code=%0d st=%0b",
                 cyc, cur[3], cur[2:1], cur[0]);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || cur !== {e.v, e.code, e.st}) begin
          errors++;
          $display("FAIL db1_event got cyc=%0d v=%0b code=%0d st=%0b exp cyc=%0d v=%0b code=%0d st=%0b",
                   cyc, cur[3], cur[2:1], cur[0], e.cyc, e.v, e.code, e.st);
        end
      end
    end
    prev1 = cur;
  end

  task automatic push0(input int unsigned c, input logic v, input logic [1:0] code, input logic st);
    ev_t e;
    e = '{cyc: c, v: v, code: code, st: st};
    q0.push_back(e);
  endtask

  task automatic push1(input int unsigned c, input logic v, input logic [1:0] code, input logic st);
    ev_t e;
    e = '{cyc: c, v: v, code: code, st: st};
    q1.push_back(e);
  endtask

  task automatic drive(input logic [3:0] b, input int n);
    BTN = b;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_start(input logic s, input int n);
    BTN_START = s;
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_reset(input string name, input logic [3:0] got);
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL %s got v/code/st=%b exp 0000", name, got);
    end
  endtask

  initial begin
    int unsigned k;
    repeat (3) @(negedge CLK);
    check_reset("reset_db4", {BTN_VALID, BTN_CODE, START_GAME});
    check_reset("reset_db1", {valid1, code1, start_game1});
    RST = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge CLK);

    // 1: clean press of colour 2, then release
    k = cyc; push0(k + 7, 1'b1, 2'd2, 1'b0);
    drive(4'b0100, 20);
    k = cyc; push0(k + 7, 1'b0, 2'd2, 1'b0);
    drive(4'b0000, 12);

    // 2: press bounce; only the final stable 0001 is accepted
    k = cyc; push0(k + 10, 1'b1, 2'd0, 1'b0);
    drive(4'b0001, 2);
    drive(4'b0000, 1);
    drive(4'b0001, 12);
    k = cyc; push0(k + 7, 1'b0, 2'd0, 1'b0);
    drive(4'b0000, 12);

    // 3: two buttons rejected, then single colour 1 accepted
    drive(4'b0011, 30);
    k = cyc; push0(k + 7, 1'b1, 2'd1, 1'b0);
    drive(4'b0010, 12);
    k = cyc; push0(k + 7, 1'b0, 2'd1, 1'b0);
    drive(4'b0000, 12);

    // 4: extra button and short release while held: no output change
    k = cyc; push0(k + 7, 1'b1, 2'd3, 1'b0);
    drive(4'b1000, 10);
    drive(4'b1001, 3);
    drive(4'b0000, 2);
    drive(4'b1000, 10);
    k = cyc; push0(k + 7, 1'b0, 2'd3, 1'b0);
    drive(4'b0000, 12);

    // 5: reset while held clears everything; re-press needs full debounce
    k = cyc; push0(k + 7, 1'b1, 2'd2, 1'b0);
    drive(4'b0100, 10);
    RST = 1'b1;
    push0(cyc + 1, 1'b0, 2'd0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    push0(cyc + 7, 1'b1, 2'd2, 1'b0);
    repeat (12) @(negedge CLK);
    k = cyc; push0(k + 7, 1'b0, 2'd2, 1'b0);
    drive(4'b0000, 12);

    // 6: start button with a glitch that must restart the count
    k = cyc; push0(k + 10, 1'b0, 2'd2, 1'b1);
    drive_start(1'b1, 3);
    drive_start(1'b0, 1);
    drive_start(1'b1, 6);
    k = cyc; push0(k + 6, 1'b0, 2'd2, 1'b0);
    drive_start(1'b0, 12);

    // DB_CYCLES=1 instance: press/release in 4 edges, start in 3
    k = cyc; push1(k + 4, 1'b1, 2'd1, 1'b0);
    btn1 = 4'b0010;
    repeat (6) @(negedge CLK);
    k = cyc; push1(k + 4, 1'b0, 2'd1, 1'b0);
    btn1 = 4'b0000;
    repeat (6) @(negedge CLK);
    k = cyc; push1(k + 3, 1'b0, 2'd1, 1'b1);
    start1 = 1'b1;
    repeat (6) @(negedge CLK);
    k = cyc; push1(k + 3, 1'b0, 2'd1, 1'b0);
    start1 = 1'b0;
    repeat (8) @(negedge CLK);

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL db4_missing got %0d pending events exp 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL db1_missing got %0d pending events exp 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
